// File: rtl/reg_file_sb.sv
// ============================================================================
// Module   : reg_file_sb
// Brief    : Integer register file with two write ports and a scoreboard
//            that tracks pending long-latency writes. Define RF_BYPASS_EN to
//            enable same-cycle write-to-read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wen0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic [DATA_W-1:0]        wdata0_i,
    input  logic                     wen1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic [DATA_W-1:0]        wdata1_i,
    input  logic                     alloc_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     flush_i,
    output logic [2**ADDR_W-1:0]     busy_vec_o,
    output logic                     waw_err_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              r_waw_err;
    logic              w_waw_set;
    logic              w_wr0_act;
    logic              w_wr1_act;

    assign w_wr0_act = wen0_i && (waddr0_i != '0);
    assign w_wr1_act = wen1_i && (waddr1_i != '0);

    // Port 0 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr1_act) r_regs[waddr1_i] <= wdata1_i;
            if (w_wr0_act) r_regs[waddr0_i] <= wdata0_i;
        end
    end

    always_comb begin
        w_busy_nxt    = r_busy;
        w_busy_nxt[0] = 1'b0;
        for (int a = 1; a < DEPTH; a++) begin
            if (flush_i) begin
                w_busy_nxt[a] = 1'b0;
            end else if (alloc_i && (alloc_addr_i == ADDR_W'(a))) begin
                w_busy_nxt[a] = 1'b1;
            end else if (wen1_i && (waddr1_i == ADDR_W'(a))) begin
                w_busy_nxt[a] = 1'b0;
            end
        end
    end

    // Hazard: ALU overtaking a pending load, or re-allocating a busy register.
    assign w_waw_set = (w_wr0_act && r_busy[waddr0_i]) ||
                       (alloc_i && (alloc_addr_i != '0) && r_busy[alloc_addr_i] &&
                        !(wen1_i && (waddr1_i == alloc_addr_i)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy    <= '0;
            r_waw_err <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_waw_err <= r_waw_err | w_waw_set;
        end
    end

    assign busy_vec_o = r_busy;
    assign waw_err_o  = r_waw_err;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;
        logic              w_rbusy;

        assign w_raddr = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rdata = r_regs[w_raddr];
            w_rbusy = r_busy[w_raddr];
`ifdef RF_BYPASS_EN
            if (w_wr1_act && (waddr1_i == w_raddr)) begin
                w_rdata = wdata1_i;
                w_rbusy = 1'b0;
            end
            if (w_wr0_act && (waddr0_i == w_raddr)) begin
                w_rdata = wdata0_i;
            end
`endif
            if (w_raddr == '0) begin
                w_rdata = '0;
                w_rbusy = 1'b0;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = w_rdata;
        assign rd_busy_o[k]                  = w_rbusy;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the RV32I core, with one read port per operand and two write ports.
  - Write port 0 is the single-cycle ALU writeback.
  - Write port 1 is the long-latency writeback (load/mul).
- An integrated scoreboard tracks registers with a pending port-1 write so issue logic can detect RAW/WAW hazards.
- Optional same-cycle write-to-read bypass.
- Sits between decode/issue and the writeback stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses slice k.
- rd_data_o  out  NUM_RD*DATA_W  read data; port k uses slice k.
- rd_busy_o  out  NUM_RD  read register k has a pending port-1 write.
- wen0_i  in  1  write enable, port 0 (ALU).
- waddr0_i  in  ADDR_W  write address, port 0.
- wdata0_i  in  DATA_W  write data, port 0.
- wen1_i  in  1  write enable, port 1 (long-latency); also retires the scoreboard entry.
- waddr1_i  in  ADDR_W  write address, port 1.
- wdata1_i  in  DATA_W  write data, port 1.
- alloc_i  in  1  mark alloc_addr_i busy (long-latency op issued).
- alloc_addr_i  in  ADDR_W  destination register being allocated.
- flush_i  in  1  clear all busy bits (pipeline flush); register contents untouched.
- busy_vec_o  out  2**ADDR_W  raw scoreboard state.
- waw_err_o  out  1  sticky hazard error flag.

Behaviour:
- Reset (rst_ni=0, asynchronous, any time including mid-write): all registers, busy bits and waw_err_o go to 0 immediately. Writes and allocs on the deasserting edge are ignored only while rst_ni=0.
- Register 0:
  - reads 0 always.
  - Writes to address 0 on either port are discarded.
  - alloc of address 0 is ignored; busy_vec_o[0] is always 0.
- Writes take effect at the rising edge.
- Simultaneous port-0 and port-1 writes to the same nonzero address: port 0 wins (younger instruction). Port 1 still clears that busy bit.
- Reads are combinational from array state, plus bypass (see Optional Feature).
- Scoreboard, per nonzero address a, next busy[a] is evaluated in this priority:
  1. flush_i → 0.
  2. alloc_i && alloc_addr_i==a → 1. Alloc wins over a same-cycle port-1 retire to a.
  3. wen1_i && waddr1_i==a → 0.
  4. Otherwise hold.
- rd_busy_o[k] = busy[rd_addr_k], except forced 0 when wen1_i is writing rd_addr_k this cycle and RF_BYPASS_EN is defined. Always 0 for address 0.
- waw_err_o: set at the edge when either condition holds. Once set, cleared only by reset.
  - wen0_i writes a nonzero address whose busy bit is 1 (ALU overtaking a pending load).
  - alloc_i targets an already busy address with no same-cycle retire of it.
- No port-level latency beyond one clock for writes/busy updates; reads are zero latency.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - A read whose address matches an active nonzero write this cycle returns the write data; port 0 takes precedence over port 1.
  - rd_busy_o is cleared for an address being retired by port 1 this cycle.
- Undefined:
  - Reads return pre-edge array contents; new data is visible from the next cycle.
  - rd_busy_o reflects the registered busy bit only.

Test Plan:
- Reset/zero: rst_ni=0 mid-write of x5=0xDEADBEEF → all reads 0, busy_vec_o=0, waw_err_o=0. Write x0=0x1234 → reads x0=0.
- Dual write: wen0 x7=0x11, wen1 x7=0x22 same cycle → next cycle x7 reads 0x11.
- Scoreboard: alloc x9 → rd_busy for x9 =1 next cycle. wen1 x9=0xABCD → busy clears. Read x9=0xABCD.
- Alloc/retire same cycle x3 → busy[3] stays 1. flush_i → busy_vec_o=0, x3 data unchanged.
- WAW: alloc x4, then wen0 x4=0x5 → waw_err_o=1 next cycle and remains 1 after the busy bit clears.
- Bypass (with RF_BYPASS_EN): read x6 while wen1 x6=0x77 → rd_data=0x77, rd_busy=0 same cycle. Without the macro → old value and busy=1.
